// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between a user byte source and a receiver echo.
// Optional macro ARB_DROP_CNT_EN adds a saturating count of overwritten pending bytes (drop_cnt).
module uart_tx_arbiter #(
  parameter int DATA_W       = 8,
  parameter int BUSY_WAIT    = 16,
  parameter bit ECHO_DEFAULT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              user_req,
  input  logic [DATA_W-1:0] user_data,
  input  logic              echo_req,
  input  logic [DATA_W-1:0] echo_data,
  input  logic              echo_en,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic [1:0]        grant,
  output logic              user_pend,
  output logic              echo_pend,
`ifdef ARB_DROP_CNT_EN
  output logic [7:0]        drop_cnt,
`endif
  output logic              timeout
);

  localparam int CNT_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                rr_q, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                upend_q, upend_d, epend_q, epend_d;
  logic [DATA_W-1:0]   udata_q, udata_d, edata_q, edata_d;
  logic                echo_gate_q;
  logic                clr_user, clr_echo, echo_acc, pick_echo;

  // Arbitration FSM; rr_q=1 means the echo source wins the next tie.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    tx_start  = 1'b0;
    timeout   = 1'b0;
    clr_user  = 1'b0;
    clr_echo  = 1'b0;
    pick_echo = epend_q & (~upend_q | rr_q);
    case (state_q)
      S_IDLE: begin
        if (upend_q || epend_q) begin
          grant_d   = pick_echo ? 2'b10 : 2'b01;
          tx_data_d = pick_echo ? edata_q : udata_q;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        tx_start = 1'b1;
        clr_user = grant_q[0];
        clr_echo = grant_q[1];
        rr_d     = grant_q[0];
        cnt_d    = '0;
        state_d  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_WAIT - 1)) begin
          timeout = 1'b1;
          grant_d = 2'b00;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          grant_d = 2'b00;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One-entry request latches; a request in the launch cycle refills the slot being cleared.
  always_comb begin
    echo_acc = echo_req & echo_gate_q;
    upend_d  = user_req | (upend_q & ~clr_user);
    epend_d  = echo_acc | (epend_q & ~clr_echo);
    udata_d  = user_req ? user_data : udata_q;
    edata_d  = echo_acc ? echo_data : edata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= 2'b00;
      tx_data_q   <= '0;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      upend_q     <= 1'b0;
      epend_q     <= 1'b0;
      echo_gate_q <= ECHO_DEFAULT;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      tx_data_q   <= tx_data_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      upend_q     <= upend_d;
      epend_q     <= epend_d;
      echo_gate_q <= echo_en;
    end
  end

  // Held bytes are only meaningful while their pend flag is set, so they carry no reset.
  always_ff @(posedge clk) begin
    udata_q <= udata_d;
    edata_q <= edata_d;
  end

`ifdef ARB_DROP_CNT_EN
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  logic [7:0] drop_q, drop_d;
  logic       u_drop, e_drop;

  always_comb begin
    u_drop = user_req & upend_q & ~clr_user;
    e_drop = echo_acc & epend_q & ~clr_echo;
    drop_d = sat_add8(drop_q, {1'b0, u_drop} + {1'b0, e_drop});
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= 8'd0;
    else     drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

  assign tx_data   = tx_data_q;
  assign grant     = grant_q;
  assign user_pend = upend_q;
  assign echo_pend = epend_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; tx_busy is driven by hand to emulate the transmitter.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst, user_req, echo_req, echo_en, tx_busy;
  logic [7:0] user_data, echo_data, tx_data;
  logic       tx_start, user_pend, echo_pend, timeout;
  logic [1:0] grant;
`ifdef ARB_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DATA_W(8), .BUSY_WAIT(16), .ECHO_DEFAULT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .user_req(user_req), .user_data(user_data),
    .echo_req(echo_req), .echo_data(echo_data), .echo_en(echo_en),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .grant(grant), .user_pend(user_pend), .echo_pend(echo_pend),
`ifdef ARB_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .timeout(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered in the LAUNCH cycle; returns in the IDLE cycle after the frame completes.
  task automatic run_frame(input logic [1:0] g, input logic [7:0] d, input string tag);
    chk({tag, "_start"}, tx_start, 1);
    chk({tag, "_grant"}, grant, g);
    chk({tag, "_data"}, tx_data, d);
    tick();
    chk({tag, "_start_off"}, tx_start, 0);
    tx_busy = 1'b1;
    tick();
    tick();
    chk({tag, "_grant_hold"}, grant, g);
    chk({tag, "_data_hold"}, tx_data, d);
    tx_busy = 1'b0;
    tick();
    chk({tag, "_grant_rel"}, grant, 0);
  endtask

  initial begin
    rst = 1'b1; user_req = 1'b0; echo_req = 1'b0; echo_en = 1'b1; tx_busy = 1'b0;
    user_data = 8'h00; echo_data = 8'h00;
    tick();
    tick();
    chk("rst_start", tx_start, 0);
    chk("rst_grant", grant, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_pend", {user_pend, echo_pend, timeout}, 0);
    rst = 1'b0;

    // single user byte, idle
    user_req = 1'b1; user_data = 8'h41;
    tick();
    user_req = 1'b0;
    chk("u1_pend", user_pend, 1);
    chk("u1_nostart", tx_start, 0);
    tick();
    run_frame(2'b01, 8'h41, "u1");
    chk("u1_pend_clr", user_pend, 0);
    chk("u1_data_after", tx_data, 8'h41);

    // tie from reset: user first, then echo
    rst = 1'b1;
    tick();
    rst = 1'b0;
    user_req = 1'b1; user_data = 8'h55; echo_req = 1'b1; echo_data = 8'hAA;
    tick();
    user_req = 1'b0; echo_req = 1'b0;
    chk("tie_pend", {user_pend, echo_pend}, 2'b11);
    tick();
    run_frame(2'b01, 8'h55, "tie_u");
    chk("tie_echo_wait", echo_pend, 1);
    tick();
    run_frame(2'b10, 8'hAA, "tie_e");

    // user-only frame hands priority to echo, so the next tie goes to echo
    user_req = 1'b1; user_data = 8'h01;
    tick();
    user_req = 1'b0;
    tick();
    run_frame(2'b01, 8'h01, "solo_u");
    user_req = 1'b1; user_data = 8'h02; echo_req = 1'b1; echo_data = 8'h03;
    tick();
    user_req = 1'b0; echo_req = 1'b0;
    tick();
    run_frame(2'b10, 8'h03, "tie2_e");
    tick();
    run_frame(2'b01, 8'h02, "tie2_u");

    // echo overwritten during a busy frame: latest byte wins, frame untouched
    user_req = 1'b1; user_data = 8'h11;
    tick();
    user_req = 1'b0;
    tick();
    chk("ow_start", tx_start, 1);
    tick();
    tx_busy = 1'b1;
    echo_req = 1'b1; echo_data = 8'h10;
    tick();
    echo_req = 1'b1; echo_data = 8'h20;
    tick();
    echo_req = 1'b0;
    chk("ow_pend", echo_pend, 1);
    chk("ow_grant_mid", grant, 2'b01);
    chk("ow_data_mid", tx_data, 8'h11);
    tx_busy = 1'b0;
    tick();
    chk("ow_grant_rel", grant, 0);
    tick();
    run_frame(2'b10, 8'h20, "ow_e");
    tick();
    tick();
    chk("ow_single", {tx_start, echo_pend}, 0);
`ifdef ARB_DROP_CNT_EN
    chk("ow_drop", drop_cnt, 1);
`endif

    // tx_busy never rises: timeout after 16 wait cycles, then pending echo is served
    user_req = 1'b1; user_data = 8'h77;
    tick();
    user_req = 1'b0;
    tick();
    chk("to_start", tx_start, 1);
    echo_req = 1'b1; echo_data = 8'h99;
    for (int i = 1; i <= 15; i++) begin
      tick();
      echo_req = 1'b0;
      chk($sformatf("to_quiet%0d", i), timeout, 0);
    end
    tick();
    chk("to_pulse", timeout, 1);
    chk("to_grant_hold", grant, 2'b01);
    tick();
    chk("to_pulse_end", timeout, 0);
    chk("to_grant_rel", grant, 0);
    tick();
    run_frame(2'b10, 8'h99, "to_e");

    // echo gate closed blocks latching; reopening restores echo
    echo_en = 1'b0;
    tick();
    echo_req = 1'b1; echo_data = 8'h33;
    tick();
    echo_req = 1'b0;
    chk("gate_nopend", echo_pend, 0);
    tick();
    tick();
    chk("gate_nostart", {tx_start, grant}, 0);
    echo_en = 1'b1;
    tick();
    echo_req = 1'b1; echo_data = 8'h44;
    tick();
    echo_req = 1'b0;
    chk("gate_pend", echo_pend, 1);
    tick();
    run_frame(2'b10, 8'h44, "gate_e");

    // reset during WAIT_DONE with a user byte pending
    user_req = 1'b1; user_data = 8'h5A;
    tick();
    user_req = 1'b0;
    tick();
    chk("rm_start", tx_start, 1);
    tick();
    tx_busy = 1'b1;
    tick();
    user_req = 1'b1; user_data = 8'h6B;
    tick();
    user_req = 1'b0;
    chk("rm_pend", user_pend, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_grant", grant, 0);
    chk("rm_data", tx_data, 0);
    chk("rm_flags", {tx_start, user_pend, echo_pend, timeout}, 0);
`ifdef ARB_DROP_CNT_EN
    chk("rm_drop", drop_cnt, 0);
`endif
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rm_nostart%0d", i), tx_start, 0);
    end
    tx_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rm_idle%0d", i), {tx_start, grant}, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
